// File: rtl/npc_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
package npc_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef enum logic [1:0] {
        IFU_BOOT,
        IFU_REQ,
        IFU_WAIT,
        IFU_HOLD
    } ifu_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time and holds
// the fetched instruction until decode takes it; execute redirects flush it.
module ifu_fetch
    import npc_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [31:0]     mem_rsp_data,
    input  logic            mem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_err
);

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            inst_err_q, inst_err_d;

    logic            req_fire;
    logic [XLEN-1:0] redirect_target;

    assign mem_req_valid   = (state_q == IFU_REQ);
    assign mem_req_addr    = pc_q;
    assign inst_valid      = (state_q == IFU_HOLD);
    assign inst            = inst_q;
    assign inst_pc         = inst_pc_q;
    assign inst_err        = inst_err_q;
    assign req_fire        = mem_req_valid & mem_req_ready;
    assign redirect_target = redirect_pc & ~XLEN'(3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IFU_BOOT;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            inst_q     <= NOP_INST;
            inst_pc_q  <= '0;
            inst_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            inst_err_q <= inst_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        inst_err_d = inst_err_q;

        unique case (state_q)
            IFU_BOOT: state_d = IFU_REQ;
            IFU_REQ: begin
                if (req_fire) state_d = IFU_WAIT;
            end
            IFU_WAIT: begin
                if (mem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = IFU_REQ;
                    end else begin
                        inst_d     = mem_rsp_err ? NOP_INST : mem_rsp_data;
                        inst_err_d = mem_rsp_err;
                        inst_pc_d  = pc_q;
                        pc_d       = pc_q + XLEN'(4);
                        state_d    = IFU_HOLD;
                    end
                end
            end
            IFU_HOLD: begin
                if (inst_ready) state_d = IFU_REQ;
            end
            default: state_d = IFU_BOOT;
        endcase

        // Redirect overrides everything above; an accepted-but-unanswered request
        // stays outstanding and is marked for discard instead of being abandoned.
        if (redirect_valid) begin
            pc_d       = redirect_target;
            inst_d     = inst_q;
            inst_pc_d  = inst_pc_q;
            inst_err_d = inst_err_q;
            drop_d     = 1'b0;
            state_d    = IFU_REQ;
            if ((state_q == IFU_REQ) && req_fire) begin
                state_d = IFU_WAIT;
                drop_d  = 1'b1;
            end else if ((state_q == IFU_WAIT) && !mem_rsp_valid) begin
                state_d = IFU_WAIT;
                drop_d  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed vector table, mid-operation reset sequence and a
// randomized run against a transaction-level model of the fetch contract.
module tb_ifu_fetch;

    localparam int unsigned XLEN   = 64;
    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        mem_rsp_err = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_err;

    always #5 clk = ~clk;

    ifu_fetch #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        redir;
        logic [63:0] rpc;
        logic        rdy;
        logic        rsp;
        logic [31:0] data;
        logic        err;
        logic        iready;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [63:0] e_ipc;
        logic        e_ierr;
    } vec_t;

    vec_t vt[$];

    task automatic v(input logic redir, input logic [63:0] rpc, input logic rdy, input logic rsp,
                     input logic [31:0] data, input logic err, input logic iready,
                     input logic e_req, input logic [63:0] e_addr, input logic e_iv,
                     input logic [31:0] e_inst, input logic [63:0] e_ipc, input logic e_ierr);
        vec_t t;
        t.redir = redir; t.rpc = rpc; t.rdy = rdy; t.rsp = rsp; t.data = data; t.err = err;
        t.iready = iready; t.e_req = e_req; t.e_addr = e_addr; t.e_iv = e_iv;
        t.e_inst = e_inst; t.e_ipc = e_ipc; t.e_ierr = e_ierr;
        vt.push_back(t);
    endtask

    task automatic drive(input logic redir, input logic [63:0] rpc, input logic rdy, input logic rsp,
                         input logic [31:0] data, input logic err, input logic iready);
        redirect_valid = redir; redirect_pc = rpc; mem_req_ready = rdy; mem_rsp_valid = rsp;
        mem_rsp_data = data; mem_rsp_err = err; inst_ready = iready;
    endtask

    // Transaction-level model state for the random run
    logic        m_boot, m_out, m_stale, m_held, m_ierr;
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_inst;
    logic        mem_pend;
    int          mem_cnt;
    int          n_deliv;

    localparam logic [31:0] A = 32'h0010_0093, B = 32'h0020_0113, X = 32'hFFFF_FFFF;
    localparam logic [31:0] C = 32'h0030_0193, D = 32'h0040_0213, E = 32'h0050_0293;
    localparam logic [31:0] F = 32'h0060_0313, G = 32'h0070_0393, H = 32'h0080_0413;

    initial begin
        // redir rpc rdy rsp data err iready | e_req e_addr e_iv e_inst e_ipc e_ierr
        v(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);                                 // BOOT
        v(0, 0, 1, 0, 0, 0, 0,   1, RST_PC, 0, 0, 0, 0);
        v(0, 0, 0, 1, A, 0, 0,   0, 0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 1,   0, 0, 1, A, RST_PC, 0);
        v(0, 0, 1, 0, 0, 0, 0,   1, RST_PC + 64'h4, 0, 0, 0, 0);
        v(0, 0, 0, 1, B, 0, 0,   0, 0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 1,   0, 0, 1, B, RST_PC + 64'h4, 0);
        v(0, 0, 1, 0, 0, 0, 0,   1, RST_PC + 64'h8, 0, 0, 0, 0);
        v(0, 0, 0, 1, X, 1, 0,   0, 0, 0, 0, 0, 0);                                 // access fault
        v(0, 0, 0, 0, 0, 0, 1,   0, 0, 1, NOP, RST_PC + 64'h8, 1);
        v(0, 0, 0, 0, 0, 0, 0,   1, RST_PC + 64'hC, 0, 0, 0, 0);                    // ready low
        v(0, 0, 1, 0, 0, 0, 0,   1, RST_PC + 64'hC, 0, 0, 0, 0);
        v(1, 64'h8000_0100, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);                     // redirect in WAIT
        v(0, 0, 0, 1, C, 0, 0,   0, 0, 0, 0, 0, 0);                                 // stale response
        v(0, 0, 1, 0, 0, 0, 0,   1, 64'h8000_0100, 0, 0, 0, 0);
        v(0, 0, 0, 1, D, 0, 0,   0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) v(0, 0, 0, 0, 0, 0, 0,   0, 0, 1, D, 64'h8000_0100, 0);
        v(0, 0, 0, 0, 0, 0, 1,   0, 0, 1, D, 64'h8000_0100, 0);
        v(0, 0, 1, 0, 0, 0, 0,   1, 64'h8000_0104, 0, 0, 0, 0);
        v(1, 64'h8000_0203, 0, 1, E, 0, 0,   0, 0, 0, 0, 0, 0);                     // redirect + response
        v(0, 0, 1, 0, 0, 0, 0,   1, 64'h8000_0200, 0, 0, 0, 0);
        v(0, 0, 0, 1, F, 0, 0,   0, 0, 0, 0, 0, 0);
        v(1, 64'h8000_0300, 0, 0, 0, 0, 1,   0, 0, 1, F, 64'h8000_0200, 0);         // redirect + inst_ready
        v(1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 0, 0,   1, 64'h8000_0300, 0, 0, 0, 0); // redirect + handshake
        v(0, 0, 0, 1, G, 0, 0,   0, 0, 0, 0, 0, 0);
        v(0, 0, 1, 0, 0, 0, 0,   1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0);
        v(0, 0, 0, 1, H, 0, 0,   0, 0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 1,   0, 0, 1, H, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        v(0, 0, 0, 0, 0, 0, 0,   1, 64'h0, 0, 0, 0, 0);                             // wrapped
        v(0, 0, 0, 1, G, 0, 0,   1, 64'h0, 0, 0, 0, 0);                             // stray response
        v(0, 0, 0, 0, 0, 0, 0,   1, 64'h0, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        chk("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_inst", {32'd0, inst}, {32'd0, NOP});
        chk("rst_inst_pc", inst_pc, 64'd0);
        chk("rst_inst_err", {63'd0, inst_err}, 64'd0);
        chk("rst_addr", mem_req_addr, RST_PC);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].redir, vt[i].rpc, vt[i].rdy, vt[i].rsp, vt[i].data, vt[i].err, vt[i].iready);
            chk($sformatf("vec%0d_req_valid", i), {63'd0, mem_req_valid}, {63'd0, vt[i].e_req});
            if (vt[i].e_req) chk($sformatf("vec%0d_req_addr", i), mem_req_addr, vt[i].e_addr);
            chk($sformatf("vec%0d_inst_valid", i), {63'd0, inst_valid}, {63'd0, vt[i].e_iv});
            if (vt[i].e_iv) begin
                chk($sformatf("vec%0d_inst", i), {32'd0, inst}, {32'd0, vt[i].e_inst});
                chk($sformatf("vec%0d_inst_pc", i), inst_pc, vt[i].e_ipc);
                chk($sformatf("vec%0d_inst_err", i), {63'd0, inst_err}, {63'd0, vt[i].e_ierr});
            end
            @(negedge clk);
        end

        // Reset asserted mid-cycle while a request is outstanding
        drive(0, 0, 1, 0, 0, 0, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        mem_req_ready = 1'b0;
        #1;
        chk("midrst_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("midrst_inst", {32'd0, inst}, {32'd0, NOP});
        chk("midrst_inst_pc", inst_pc, 64'd0);
        chk("midrst_addr", mem_req_addr, RST_PC);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
        chk("midrst_boot_req", {63'd0, mem_req_valid}, 64'd0);
        @(negedge clk);
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("midrst_req_after", {63'd0, mem_req_valid}, 64'd1);
        chk("midrst_addr_after", mem_req_addr, RST_PC);
        @(negedge clk);
        drive(0, 0, 0, 1, 32'h1234_5678, 0, 0);
        chk("midrst_wait_req", {63'd0, mem_req_valid}, 64'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("midrst_inst_valid", {63'd0, inst_valid}, 64'd1);
        chk("midrst_inst_new", {32'd0, inst}, 64'h1234_5678);
        chk("midrst_inst_pc_new", inst_pc, RST_PC);

        // Randomized run against the transaction model
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_boot = 1; m_out = 0; m_stale = 0; m_held = 0; m_pc = RST_PC;
        m_ipc = 0; m_inst = NOP; m_ierr = 0;
        mem_pend = 0; mem_cnt = 0; n_deliv = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        exp_req, hs, redir, rdy, rsp, err, irdy;
            logic [63:0] rpc;
            logic [31:0] data;

            exp_req = !m_boot && !m_out && !m_held;
            chk("rnd_req_valid", {63'd0, mem_req_valid}, {63'd0, exp_req});
            if (exp_req) chk("rnd_req_addr", mem_req_addr, m_pc);
            chk("rnd_inst_valid", {63'd0, inst_valid}, {63'd0, m_held});
            if (m_held) begin
                chk("rnd_inst", {32'd0, inst}, {32'd0, m_inst});
                chk("rnd_inst_pc", inst_pc, m_ipc);
                chk("rnd_inst_err", {63'd0, inst_err}, {63'd0, m_ierr});
            end

            redir = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            else rpc = {32'd0, $urandom};
            rdy  = ($urandom_range(0, 3) != 0);
            rsp  = mem_pend ? (mem_cnt == 0) : ($urandom_range(0, 15) == 0);
            data = $urandom;
            err  = ($urandom_range(0, 7) == 0);
            irdy = ($urandom_range(0, 2) != 0);
            drive(redir, rpc, rdy, rsp, data, err, irdy);

            @(posedge clk);
            hs = exp_req && rdy;
            if (redir) begin
                m_pc   = rpc & ~64'h3;
                m_held = 1'b0;
                if (m_out && rsp) m_out = 1'b0;
                else if (m_out) m_stale = 1'b1;
                if (hs) begin m_out = 1'b1; m_stale = 1'b1; end
            end else if (hs) begin
                m_out = 1'b1; m_stale = 1'b0;
            end else if (m_out && rsp) begin
                m_out = 1'b0;
                if (!m_stale) begin
                    m_held = 1'b1;
                    m_inst = err ? NOP : data;
                    m_ierr = err;
                    m_ipc  = m_pc;
                    m_pc   = m_pc + 64'h4;
                    n_deliv++;
                end
            end else if (m_held && irdy) begin
                m_held = 1'b0;
            end
            m_boot = 1'b0;

            if (mem_pend && rsp) mem_pend = 1'b0;
            else if (mem_pend) mem_cnt--;
            if (hs) begin mem_pend = 1'b1; mem_cnt = $urandom_range(0, 2); end
            @(negedge clk);
        end
        chk("rnd_progress", {63'd0, n_deliv > 20}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
